// File: rtl/fft_in_framer.sv
// Input framer for an FFT core: widens 16-bit complex samples to 32 bits, tags the
// last sample of each FFT_LEN frame, and buffers through an output register plus skid.
module fft_in_framer #(
    parameter int FFT_LEN  = 1024,
    parameter int SCALE_SH = 0,
    localparam int IDX_W   = $clog2(FFT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      s_re,
    input  logic [15:0]      s_im,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [31:0]      m_re,
    output logic [31:0]      m_im,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [IDX_W-1:0] sample_idx,
    output logic             frame_done,
    output logic [1:0]       dbg_state
);

    // Handshake: a beat moves when valid and ready are both high in the same cycle;
    // valid never waits for ready, and s_tready comes straight from a flop.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] skid_re;
    logic [31:0] skid_im;
    logic        skid_last;

    logic        in_xfer;
    logic        out_xfer;
    logic [31:0] in_re_w;
    logic [31:0] in_im_w;
    logic        in_last;

    assign dbg_state = state;
    assign in_xfer   = s_tvalid & s_tready;
    assign out_xfer  = m_tvalid & m_tready;

    // The headroom above bit 15 absorbs any shift up to 16, so no overflow is possible.
    assign in_re_w = {{16{s_re[15]}}, s_re} << SCALE_SH;
    assign in_im_w = {{16{s_im[15]}}, s_im} << SCALE_SH;
    assign in_last = (sample_idx == IDX_W'(FFT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_re       <= '0;
            m_im       <= '0;
            skid_re    <= '0;
            skid_im    <= '0;
            skid_last  <= 1'b0;
            sample_idx <= '0;
            s_tready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_xfer & m_tlast;
            s_tready   <= 1'b1;
            // Power-of-two length lets the index wrap naturally after the tlast sample.
            if (in_xfer) begin
                sample_idx <= sample_idx + IDX_W'(1);
            end

            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        m_re     <= in_re_w;
                        m_im     <= in_im_w;
                        m_tlast  <= in_last;
                        m_tvalid <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_re   <= in_re_w;
                        skid_im   <= in_im_w;
                        skid_last <= in_last;
                        s_tready  <= 1'b0;
                        state     <= TWO;
                    end else if (in_xfer) begin
                        m_re    <= in_re_w;
                        m_im    <= in_im_w;
                        m_tlast <= in_last;
                    end else if (out_xfer) begin
                        m_tvalid <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        m_re    <= skid_re;
                        m_im    <= skid_im;
                        m_tlast <= skid_last;
                        state   <= ONE;
                    end else begin
                        s_tready <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    m_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_in_framer.sv
// Bench for fft_in_framer: four parameterisations share one stimulus bus; a queue-based
// reference model checks the selected instance every cycle on the falling edge.
module tb_fft_in_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_re;
    logic [15:0] s_im;
    logic        s_tvalid;
    logic        m_tready;

    logic [31:0] o_re[4];
    logic [31:0] o_im[4];
    logic        o_tlast[4];
    logic        o_tvalid[4];
    logic        o_str[4];
    logic        o_fd[4];
    logic [1:0]  o_st[4];
    logic [1:0]  idx_a;
    logic [1:0]  idx_b;
    logic [3:0]  idx_c;
    logic [2:0]  idx_d;

    always #5 clk = ~clk;

    fft_in_framer #(.FFT_LEN(4), .SCALE_SH(0)) u_len4 (
        .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_tvalid(s_tvalid), .s_tready(o_str[0]),
        .m_re(o_re[0]), .m_im(o_im[0]), .m_tlast(o_tlast[0]), .m_tvalid(o_tvalid[0]),
        .m_tready(m_tready), .sample_idx(idx_a), .frame_done(o_fd[0]), .dbg_state(o_st[0]));
    fft_in_framer #(.FFT_LEN(4), .SCALE_SH(16)) u_len4_sh16 (
        .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_tvalid(s_tvalid), .s_tready(o_str[1]),
        .m_re(o_re[1]), .m_im(o_im[1]), .m_tlast(o_tlast[1]), .m_tvalid(o_tvalid[1]),
        .m_tready(m_tready), .sample_idx(idx_b), .frame_done(o_fd[1]), .dbg_state(o_st[1]));
    fft_in_framer #(.FFT_LEN(16), .SCALE_SH(0)) u_len16 (
        .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_tvalid(s_tvalid), .s_tready(o_str[2]),
        .m_re(o_re[2]), .m_im(o_im[2]), .m_tlast(o_tlast[2]), .m_tvalid(o_tvalid[2]),
        .m_tready(m_tready), .sample_idx(idx_c), .frame_done(o_fd[2]), .dbg_state(o_st[2]));
    fft_in_framer #(.FFT_LEN(8), .SCALE_SH(0)) u_len8 (
        .clk(clk), .rst(rst), .s_re(s_re), .s_im(s_im), .s_tvalid(s_tvalid), .s_tready(o_str[3]),
        .m_re(o_re[3]), .m_im(o_im[3]), .m_tlast(o_tlast[3]), .m_tvalid(o_tvalid[3]),
        .m_tready(m_tready), .sample_idx(idx_d), .frame_done(o_fd[3]), .dbg_state(o_st[3]));

    int lens[4] = '{4, 4, 16, 8};
    int shs[4]  = '{0, 16, 0, 0};
    int sel;

    logic [31:0] mon_re, mon_im;
    logic        mon_tlast, mon_tvalid, mon_str, mon_fd;
    logic [1:0]  mon_st;
    logic [15:0] mon_idx;

    always_comb begin
        mon_re     = o_re[sel];
        mon_im     = o_im[sel];
        mon_tlast  = o_tlast[sel];
        mon_tvalid = o_tvalid[sel];
        mon_str    = o_str[sel];
        mon_fd     = o_fd[sel];
        mon_st     = o_st[sel];
        case (sel)
            0:       mon_idx = {14'd0, idx_a};
            1:       mon_idx = {14'd0, idx_b};
            2:       mon_idx = {12'd0, idx_c};
            default: mon_idx = {13'd0, idx_d};
        endcase
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
    } item_t;

    item_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    acc_cnt  = 0;  // samples accepted since last reset
    int    n_in     = 0;
    int    n_out    = 0;
    int    n_tlast  = 0;
    int    fd_seen  = 0;
    logic  exp_str  = 1'b0;
    logic  exp_fd   = 1'b0;
    logic  post_rst = 1'b0;
    logic  armed    = 1'b0;

    function automatic logic [31:0] widen(input logic [15:0] v, input int sh);
        longint x;
        x = longint'($signed(v)) * (longint'(1) << sh);
        return x[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        if (!armed) return;
        chk("m_tvalid", {31'd0, mon_tvalid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            chk("m_re", mon_re, exp_q[0].re);
            chk("m_im", mon_im, exp_q[0].im);
            chk("m_tlast", {31'd0, mon_tlast}, {31'd0, exp_q[0].last});
        end
        chk("s_tready", {31'd0, mon_str}, {31'd0, exp_str});
        chk("frame_done", {31'd0, mon_fd}, {31'd0, exp_fd});
        chk("sample_idx", {16'd0, mon_idx}, 32'(acc_cnt % lens[sel]));
        chk("occupancy", {30'd0, mon_st}, 32'(exp_q.size()));
        if (post_rst) begin
            chk("rst_m_re", mon_re, 32'd0);
            chk("rst_m_im", mon_im, 32'd0);
            chk("rst_m_tlast", {31'd0, mon_tlast}, 32'd0);
        end
        if (mon_fd) fd_seen++;
    endtask

    // One clock cycle: check at the falling edge, drive new inputs, then advance the model.
    task automatic tick(input logic v, input logic [15:0] re, input logic [15:0] im,
                        input logic rdy, input logic r, output logic acc);
        logic   str_before;
        logic   in_x;
        logic   out_x;
        item_t  it;
        @(negedge clk);
        check_outputs();
        str_before = mon_str;
        s_tvalid = v;
        s_re     = re;
        s_im     = im;
        m_tready = rdy;
        rst      = r;
        #1;
        if (armed) chk("s_tready_static", {31'd0, mon_str}, {31'd0, str_before});
        acc = 1'b0;
        if (r) begin
            exp_q.delete();
            acc_cnt  = 0;
            exp_str  = 1'b0;
            exp_fd   = 1'b0;
            post_rst = 1'b1;
            armed    = 1'b1;
        end else begin
            post_rst = 1'b0;
            in_x  = v && exp_str;
            out_x = (exp_q.size() != 0) && rdy;
            exp_fd = out_x && exp_q[0].last;
            if (out_x) begin
                if (exp_q[0].last) n_tlast++;
                void'(exp_q.pop_front());
                n_out++;
            end
            if (in_x) begin
                it.re   = widen(re, shs[sel]);
                it.im   = widen(im, shs[sel]);
                it.last = ((acc_cnt % lens[sel]) == lens[sel] - 1);
                exp_q.push_back(it);
                acc_cnt++;
                n_in++;
                acc = 1'b1;
            end
            exp_str = (exp_q.size() < 2);
        end
    endtask

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] re0;
        logic [31:0] im0;
        logic [31:0] re16;
        logic [31:0] im16;
    } wvec_t;

    wvec_t wv[4];

    initial begin
        logic acc;
        int   base_tl;
        int   base_fd;
        int   base_in;
        int   cyc;

        wv[0] = '{16'h8000, 16'h7FFF, 32'hFFFF8000, 32'h00007FFF, 32'h80000000, 32'h7FFF0000};
        wv[1] = '{16'h0001, 16'hFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00010000, 32'hFFFF0000};
        wv[2] = '{16'h1234, 16'hEDCC, 32'h00001234, 32'hFFFFEDCC, 32'h12340000, 32'hEDCC0000};
        wv[3] = '{16'h0000, 16'h7F00, 32'h00000000, 32'h00007F00, 32'h00000000, 32'h7F000000};

        sel = 0;
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_re = '0;
        s_im = '0;
        m_tready = 1'b0;

        // Widening table, checked on both the unshifted and the 16-bit-shifted instance.
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, wv[i].re, wv[i].im, 1'b1, 1'b0, acc);
            @(posedge clk);
            #1;
            chk("widen_re_sh0", o_re[0], wv[i].re0);
            chk("widen_im_sh0", o_im[0], wv[i].im0);
            chk("widen_re_sh16", o_re[1], wv[i].re16);
            chk("widen_im_sh16", o_im[1], wv[i].im16);
        end

        // Back-to-back 1..8 into a length-4 framer: two frames, two frame_done pulses.
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        base_tl = n_tlast;
        base_fd = fd_seen;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 16'(i), 16'(i), 1'b1, 1'b0, acc);
            chk("b2b_accept", {31'd0, acc}, 32'd1);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        chk("b2b_tlast_count", 32'(n_tlast - base_tl), 32'd2);
        chk("b2b_frame_done_count", 32'(fd_seen - base_fd), 32'd2);

        // Back-pressure: only two of three offered samples fit, then the stall releases.
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, acc);
        base_in = n_in;
        tick(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, acc);
        tick(1'b1, 16'd2, 16'd2, 1'b0, 1'b0, acc);
        tick(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, acc);
        tick(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, acc);
        chk("stall_accepted", 32'(n_in - base_in), 32'd2);
        chk("stall_third_held", {31'd0, acc}, 32'd0);
        tick(1'b1, 16'd3, 16'd3, 1'b1, 1'b0, acc);
        cyc = 0;
        while (!acc && cyc < 10) begin
            tick(1'b1, 16'd3, 16'd3, 1'b1, 1'b0, acc);
            cyc++;
        end
        chk("stall_third_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Randomised valid/ready on the length-16 instance.
        sel = 2;
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, acc);
        base_in = n_in;
        n_out = 0;
        n_tlast = 0;
        cyc = 0;
        while ((n_in - base_in) < 10000 && cyc < 60000) begin
            tick(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'b0, acc);
            cyc++;
        end
        chk("rand_timeout", {31'd0, (n_in - base_in) >= 10000}, 32'd1);
        for (int i = 0; i < 4; i++) tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_tlast_every16", 32'(n_tlast), 32'(n_out / 16));

        // Mid-frame reset on the length-8 instance discards buffered data.
        sel = 3;
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        for (int i = 1; i <= 5; i++) tick(1'b1, 16'(i), 16'(100 + i), 1'b1, 1'b0, acc);
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b1, acc);
        @(negedge clk);
        #1;
        chk("midrst_m_tvalid", {31'd0, o_tvalid[3]}, 32'd0);
        chk("midrst_sample_idx", {29'd0, idx_d}, 32'd0);
        tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        base_tl = n_tlast;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 16'(200 + i), 16'(300 + i), 1'b1, 1'b0, acc);
            chk("midrst_accept", {31'd0, acc}, 32'd1);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0, acc);
        chk("midrst_tlast_count", 32'(n_tlast - base_tl), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_in_framer.md
FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 The block SHALL have parameter FFT_LEN, default 1024, meaning samples per frame; it SHALL be a power of two in the range 4..65536.
REQ-002 The block SHALL have parameter SCALE_SH, default 0, meaning the left shift (0..16) applied after sign extension.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port s_re, input, 16 bits: signed real part of the input sample.
REQ-006 The block SHALL have port s_im, input, 16 bits: signed imaginary part of the input sample.
REQ-007 The block SHALL have port s_tvalid, input, 1 bit, and port s_tready, output, 1 bit: the input handshake.
REQ-008 The block SHALL have port m_re, output, 32 bits, and port m_im, output, 32 bits: the widened sample.
REQ-009 The block SHALL have port m_tlast, output, 1 bit: marks the last sample of a frame.
REQ-010 The block SHALL have port m_tvalid, output, 1 bit, and port m_tready, input, 1 bit: the output handshake.
REQ-011 The block SHALL have port sample_idx, output, log2(FFT_LEN) bits: index of the next sample to be accepted at the input.
REQ-012 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when a tlast beat transfers at the output.

Function
REQ-013 An input transfer SHALL occur in a cycle where s_tvalid and s_tready are both 1; an output transfer SHALL occur in a cycle where m_tvalid and m_tready are both 1.
REQ-014 Widening SHALL be: output = sign-extend the 16-bit value to 32 bits, then arithmetic shift left by SCALE_SH; the result cannot overflow, and bits shifted in SHALL be 0.
REQ-015 tlast generation:
- sample_idx increments by 1 on each input transfer.
- The sample accepted with sample_idx == FFT_LEN-1 carries tlast=1.
- sample_idx wraps to 0 after that sample.
REQ-016 Buffering SHALL be two stages: an output register plus a one-entry skid register, giving states EMPTY, ONE (output register full) and TWO (both full).
REQ-017 s_tready SHALL be a registered signal equal to (state != TWO); it SHALL NOT depend combinationally on m_tready.
REQ-018 Latency: a sample accepted in cycle N SHALL appear on m_* in cycle N+1 when the output register was empty or transferring in cycle N.
REQ-019 State transitions (in = input transfer, out = output transfer):
- EMPTY: in -> ONE.
- ONE: in and not out -> TWO; out and not in -> EMPTY; in and out -> ONE, with the new sample loaded into the output register.
- TWO: out -> ONE, with the skid contents moved to the output register; no in is possible.
REQ-020 Order SHALL be strictly preserved, and each input sample SHALL appear at the output exactly once together with its own tlast bit.
REQ-021 m_re, m_im and m_tlast SHALL hold their values while m_tvalid=1 and m_tready=0.
REQ-022 frame_done SHALL be registered and asserted in cycle N+1 after an output transfer with m_tlast=1 in cycle N.
REQ-023 Simultaneous input and output transfers in the same cycle SHALL sustain full throughput, one sample per cycle, with no bubbles.

Reset
REQ-024 While rst=1, at the next clock edge the block SHALL set state EMPTY, m_tvalid=0, m_tlast=0, m_re=0, m_im=0, sample_idx=0, s_tready=0 and frame_done=0.
REQ-025 In the cycle after rst deasserts, s_tready SHALL be 1.
REQ-026 Reset mid-frame SHALL discard all buffered samples and restart framing at index 0; no partial-frame tlast is emitted.

Verification
REQ-027 FFT_LEN=4, SCALE_SH=0, m_tready=1, back-to-back inputs 1..8 -> outputs 1..8, one per cycle, one cycle late; tlast on samples 4 and 8; frame_done pulses twice.
REQ-028 Input s_re=0x8000, s_im=0x7FFF with SCALE_SH=16 -> m_re=0x80000000, m_im=0x7FFF0000; with SCALE_SH=0 -> m_re=0xFFFF8000, m_im=0x00007FFF.
REQ-029 m_tready=0 while sending 3 inputs -> exactly 2 accepted, s_tready=0 from the cycle after the 2nd acceptance; release m_tready -> order 1,2,3 preserved with no loss or duplication.
REQ-030 Random s_tvalid and m_tready at 50% each over 10 000 samples, FFT_LEN=16 -> scoreboard match, tlast every 16th output, s_tready never combinationally tracks m_tready.
REQ-031 Assert rst for 1 cycle after 5 of 8 samples, FFT_LEN=8 -> m_tvalid=0 and sample_idx=0 the next cycle; the following 8 inputs give tlast on the 8th only.
